// File: rtl/if_id_pipe_reg_if.sv
// Fetch-to-decode bundle for the IF/ID pipeline register.
// The fetch side drives the master modport and the register uses the slave modport.
interface if_id_pipe_reg_if #(
  parameter int INSTRUCTION = 32,
  parameter int ADDRESS     = 32,
  parameter int CNT_WIDTH   = 16
);
  logic [ADDRESS-1:0]     pre_address_fetch;
  logic [INSTRUCTION-1:0] instruction_fetch;
  logic                   next_select;
  logic                   branch_result;
  logic                   Jalr;
  logic                   load;
  logic                   count_clear;
  logic [ADDRESS-1:0]     pre_pc_fetch_pp;
  logic [INSTRUCTION-1:0] instruction_fetch_pp;
  logic                   valid_pp;
  logic                   flushing;
  logic [CNT_WIDTH-1:0]   bubble_count;

  modport master (
    output pre_address_fetch, instruction_fetch, next_select, branch_result,
           Jalr, load, count_clear,
    input  pre_pc_fetch_pp, instruction_fetch_pp, valid_pp, flushing, bubble_count
  );

  modport slave (
    input  pre_address_fetch, instruction_fetch, next_select, branch_result,
           Jalr, load, count_clear,
    output pre_pc_fetch_pp, instruction_fetch_pp, valid_pp, flushing, bubble_count
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with redirect flush countdown, load-use hold,
// valid bit and a saturating count of inserted bubbles.
module if_id_pipe_reg #(
  parameter int                     INSTRUCTION  = 32,
  parameter int                     ADDRESS      = 32,
  parameter int                     FLUSH_CYCLES = 2,
  parameter logic [INSTRUCTION-1:0] NOP_INSTR    = 32'h0000_0000,
  parameter int                     CNT_WIDTH    = 16
) (
  input logic             clk,
  input logic             rst,
  if_id_pipe_reg_if.slave bus
);
  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0]      FLUSH_LOAD = FC_W'(FLUSH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [FC_W-1:0]        flush_cnt;
  logic [ADDRESS-1:0]     pc_q;
  logic [INSTRUCTION-1:0] instr_q;
  logic                   valid_q;
  logic [CNT_WIDTH-1:0]   bubble_cnt_q;
  logic                   redirect;
  logic                   bubble;

  assign redirect = bus.next_select | bus.branch_result | bus.Jalr;
  // Any edge that loads a bubble, whether the redirect itself or the countdown after it.
  assign bubble   = redirect | (flush_cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      flush_cnt <= '0;
    end else if (redirect) begin
      pc_q      <= '0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      flush_cnt <= FLUSH_LOAD;
    end else if (flush_cnt != '0) begin
      pc_q      <= '0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      flush_cnt <= flush_cnt - 1'b1;
    end else if (!bus.load) begin
      pc_q      <= bus.pre_address_fetch;
      instr_q   <= bus.instruction_fetch;
      valid_q   <= 1'b1;
    end
  end

  // A clear coinciding with a bubble still records that bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (bus.count_clear) begin
      bubble_cnt_q <= bubble ? CNT_WIDTH'(1) : '0;
    end else if (bubble && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bus.pre_pc_fetch_pp      = pc_q;
  assign bus.instruction_fetch_pp = instr_q;
  assign bus.valid_pp             = valid_q;
  assign bus.flushing             = (flush_cnt != '0);
  assign bus.bubble_count         = bubble_cnt_q;
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: default instance plus a small-counter,
// single-bubble instance with a non-zero NOP encoding.
module tb_if_id_pipe_reg;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  // Observation vector: {pc, instr, valid, flushing, bubble_count}
  typedef logic [81:0] snap1_t;
  typedef logic [67:0] snap2_t;

  if_id_pipe_reg_if #(.INSTRUCTION(32), .ADDRESS(32), .CNT_WIDTH(16)) bus  ();
  if_id_pipe_reg_if #(.INSTRUCTION(32), .ADDRESS(32), .CNT_WIDTH(2))  bus2 ();

  if_id_pipe_reg #(
    .INSTRUCTION(32), .ADDRESS(32), .FLUSH_CYCLES(2),
    .NOP_INSTR(32'h0000_0000), .CNT_WIDTH(16)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  if_id_pipe_reg #(
    .INSTRUCTION(32), .ADDRESS(32), .FLUSH_CYCLES(0),
    .NOP_INSTR(32'h0000_0013), .CNT_WIDTH(2)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap1_t snap1();
    return {bus.pre_pc_fetch_pp, bus.instruction_fetch_pp, bus.valid_pp,
            bus.flushing, bus.bubble_count};
  endfunction

  function automatic snap2_t snap2();
    return {bus2.pre_pc_fetch_pp, bus2.instruction_fetch_pp, bus2.valid_pp,
            bus2.flushing, bus2.bubble_count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
    bus.pre_address_fetch = pc;
    bus.instruction_fetch = instr;
  endtask

  task automatic test_reset();
    snap1_t e1;
    snap2_t e2;
    #3;
    e1 = {32'h0, 32'h0, 1'b0, 1'b0, 16'd0};
    tests_run++;
    if (snap1() !== e1) begin
      tests_failed++;
      $display("FAIL reset_in_rst got %h exp %h", snap1(), e1);
    end
    e2 = {32'h0, 32'h0000_0013, 1'b0, 1'b0, 2'd0};
    tests_run++;
    if (snap2() !== e2) begin
      tests_failed++;
      $display("FAIL reset_dut2_nop got %h exp %h", snap2(), e2);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tests_run++;
    if (snap1() !== e1) begin
      tests_failed++;
      $display("FAIL reset_released got %h exp %h", snap1(), e1);
    end
  endtask

  task automatic test_normal_flow();
    snap1_t e;
    drive(32'h100, 32'h0050_0093);
    step();
    e = {32'h100, 32'h0050_0093, 1'b1, 1'b0, 16'd0};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL normal_first got %h exp %h", snap1(), e);
    end
    drive(32'h104, 32'h0010_8113);
    step();
    e = {32'h104, 32'h0010_8113, 1'b1, 1'b0, 16'd0};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL normal_second got %h exp %h", snap1(), e);
    end
  endtask

  task automatic test_redirect();
    snap1_t e;
    logic [2:0] exp_flush;
    exp_flush = 3'b110;
    drive(32'h108, 32'h1111_1111);
    bus.Jalr = 1'b1;
    step();
    bus.Jalr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = {32'h0, 32'h0, 1'b0, exp_flush[2-i], 16'(i + 1)};
      tests_run++;
      if (snap1() !== e) begin
        tests_failed++;
        $display("FAIL redirect_bubble%0d got %h exp %h", i, snap1(), e);
      end
      if (i < 2) step();
    end
    drive(32'h10c, 32'h2222_2222);
    step();
    e = {32'h10c, 32'h2222_2222, 1'b1, 1'b0, 16'd3};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL redirect_resume got %h exp %h", snap1(), e);
    end
  endtask

  task automatic test_retrigger();
    snap1_t e;
    logic [3:0] exp_flush;
    exp_flush = 4'b1110;
    drive(32'h110, 32'h3333_3333);
    bus.count_clear = 1'b1;
    step();
    bus.count_clear = 1'b0;
    e = {32'h110, 32'h3333_3333, 1'b1, 1'b0, 16'd0};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL clear_idle got %h exp %h", snap1(), e);
    end
    bus.branch_result = 1'b1;
    step();
    bus.branch_result = 1'b0;
    bus.next_select   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = {32'h0, 32'h0, 1'b0, exp_flush[3-i], 16'(i + 1)};
      tests_run++;
      if (snap1() !== e) begin
        tests_failed++;
        $display("FAIL retrigger_bubble%0d got %h exp %h", i, snap1(), e);
      end
      if (i < 3) step();
      bus.next_select = 1'b0;
    end
    drive(32'h114, 32'h4444_4444);
    step();
    e = {32'h114, 32'h4444_4444, 1'b1, 1'b0, 16'd4};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL retrigger_resume got %h exp %h", snap1(), e);
    end
  endtask

  task automatic test_load_stall();
    snap1_t e;
    drive(32'h200, 32'h00A0_0513);
    bus.count_clear = 1'b1;
    step();
    bus.count_clear = 1'b0;
    bus.load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h204 + 32'(4 * i), 32'hDEAD_0000 + 32'(i));
      step();
      e = {32'h200, 32'h00A0_0513, 1'b1, 1'b0, 16'd0};
      tests_run++;
      if (snap1() !== e) begin
        tests_failed++;
        $display("FAIL stall_hold%0d got %h exp %h", i, snap1(), e);
      end
    end
    bus.load = 1'b0;
    drive(32'h300, 32'h0030_0193);
    step();
    e = {32'h300, 32'h0030_0193, 1'b1, 1'b0, 16'd0};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL stall_release got %h exp %h", snap1(), e);
    end
  endtask

  task automatic test_simultaneous();
    snap1_t e;
    logic [3:0] exp_flush;
    exp_flush = 4'b1100;
    bus.load        = 1'b1;
    bus.next_select = 1'b1;
    drive(32'h400, 32'h5555_5555);
    step();
    bus.next_select = 1'b0;
    // Load stays high through the countdown and one more edge (stall on a bubble).
    for (int i = 0; i < 4; i++) begin
      e = {32'h0, 32'h0, 1'b0, exp_flush[3-i], 16'((i < 3) ? i + 1 : 3)};
      tests_run++;
      if (snap1() !== e) begin
        tests_failed++;
        $display("FAIL simul_bubble%0d got %h exp %h", i, snap1(), e);
      end
      if (i < 3) step();
    end
    bus.load = 1'b0;
    drive(32'h500, 32'h6666_6666);
    step();
    e = {32'h500, 32'h6666_6666, 1'b1, 1'b0, 16'd3};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL simul_resume got %h exp %h", snap1(), e);
    end
  endtask

  task automatic test_reset_mid_flush();
    snap1_t e;
    bus.Jalr = 1'b1;
    step();
    bus.Jalr = 1'b0;
    e = {32'h0, 32'h0, 1'b0, 1'b1, 16'd4};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL midflush_pre got %h exp %h", snap1(), e);
    end
    #2 rst = 1'b1;
    #1;
    e = {32'h0, 32'h0, 1'b0, 1'b0, 16'd0};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL midflush_async got %h exp %h", snap1(), e);
    end
    #2 rst = 1'b0;
    drive(32'h600, 32'h7777_7777);
    step();
    e = {32'h600, 32'h7777_7777, 1'b1, 1'b0, 16'd0};
    tests_run++;
    if (snap1() !== e) begin
      tests_failed++;
      $display("FAIL midflush_resume got %h exp %h", snap1(), e);
    end
  endtask

  task automatic test_counter_saturate();
    snap2_t e;
    bus2.next_select = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      e = {32'h0, 32'h0000_0013, 1'b0, 1'b0, 2'((i < 3) ? i + 1 : 3)};
      tests_run++;
      if (snap2() !== e) begin
        tests_failed++;
        $display("FAIL sat_redirect%0d got %h exp %h", i, snap2(), e);
      end
    end
    bus2.next_select       = 1'b0;
    bus2.pre_address_fetch = 32'h700;
    bus2.instruction_fetch = 32'h0000_1234;
    step();
    e = {32'h700, 32'h0000_1234, 1'b1, 1'b0, 2'd3};
    tests_run++;
    if (snap2() !== e) begin
      tests_failed++;
      $display("FAIL sat_single_bubble got %h exp %h", snap2(), e);
    end
    bus2.count_clear = 1'b1;
    bus2.Jalr        = 1'b1;
    step();
    bus2.Jalr = 1'b0;
    e = {32'h0, 32'h0000_0013, 1'b0, 1'b0, 2'd1};
    tests_run++;
    if (snap2() !== e) begin
      tests_failed++;
      $display("FAIL clear_with_bubble got %h exp %h", snap2(), e);
    end
    step();
    bus2.count_clear = 1'b0;
    e = {32'h700, 32'h0000_1234, 1'b1, 1'b0, 2'd0};
    tests_run++;
    if (snap2() !== e) begin
      tests_failed++;
      $display("FAIL clear_no_bubble got %h exp %h", snap2(), e);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    drive(32'h0, 32'h0);
    bus.next_select        = 1'b0;
    bus.branch_result      = 1'b0;
    bus.Jalr               = 1'b0;
    bus.load               = 1'b0;
    bus.count_clear        = 1'b0;
    bus2.pre_address_fetch = 32'h0;
    bus2.instruction_fetch = 32'h0;
    bus2.next_select       = 1'b0;
    bus2.branch_result     = 1'b0;
    bus2.Jalr              = 1'b0;
    bus2.load              = 1'b0;
    bus2.count_clear       = 1'b0;

    test_reset();
    test_normal_flow();
    test_redirect();
    test_retrigger();
    test_load_stall();
    test_simultaneous();
    test_reset_mid_flush();
    test_counter_saturate();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Parametrised IF/ID pipeline register; next generation of the fetch-stage pipe.
- Sits between instruction fetch and decode.
- Captures PC and instruction, and inserts a configurable number of bubbles after a control-flow redirect (jal, jalr, taken branch).
- Holds its contents during load-use stalls; adds a valid bit, async reset, configurable NOP encoding and a saturating bubble counter.

Parameters:
- INSTRUCTION, 32, instruction width in bits.
- ADDRESS, 32, PC width in bits.
- FLUSH_CYCLES, 2, extra bubble cycles inserted after the redirect cycle itself; 0 means a single bubble.
- NOP_INSTR, 32'h0000_0000, encoding driven on the instruction output during a bubble; width INSTRUCTION.
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- pre_address_fetch  input  ADDRESS  PC of the instruction being fetched.
- instruction_fetch  input  INSTRUCTION  fetched instruction.
- next_select  input  1  jal redirect.
- branch_result  input  1  taken-branch redirect.
- Jalr  input  1  jalr redirect.
- load  input  1  load-use stall request.
- count_clear  input  1  synchronous clear of bubble_count.
- pre_pc_fetch_pp  output  ADDRESS  registered PC.
- instruction_fetch_pp  output  INSTRUCTION  registered instruction, or NOP_INSTR during a bubble.
- valid_pp  output  1  high when the registered instruction is real (not a bubble).
- flushing  output  1  high while the flush countdown is nonzero.
- bubble_count  output  CNT_WIDTH  saturating count of bubble cycles inserted.

Behaviour:
- Reset (async assert, sync release):
  - pre_pc_fetch_pp = 0, instruction_fetch_pp = NOP_INSTR, valid_pp = 0.
  - Flush counter = 0, flushing = 0, bubble_count = 0.
  - Reset mid-flush abandons the countdown.
- redirect = next_select | branch_result | Jalr.
- Flush counter width is max(1, $clog2(FLUSH_CYCLES+1)). flushing = (counter != 0), combinational from the register.
- Per-posedge priority, highest first:
  1. redirect: load a bubble (pc 0, instr NOP_INSTR, valid 0); counter <= FLUSH_CYCLES. A redirect during an active countdown reloads the counter to FLUSH_CYCLES.
  2. counter != 0: load a bubble; counter <= counter - 1.
  3. load: hold pc, instr and valid unchanged. A stall during a bubble keeps the bubble.
  4. otherwise: pc <= pre_address_fetch, instr <= instruction_fetch, valid <= 1.
- Bubble cycle count:
  - A redirect produces exactly FLUSH_CYCLES+1 consecutive bubble edges, absent further redirects.
  - load asserted during a countdown is ignored; the bubble takes priority.
- bubble_count:
  - Increments by 1 on every edge taking branch 1 or 2, and saturates at 2^CNT_WIDTH-1.
  - count_clear sets it to 0; if a bubble occurs in the same cycle, the result is 1.
- Latency: 1 cycle from fetch inputs to outputs. No combinational path from inputs to outputs.
- Simultaneous redirect and load: redirect wins.

Test Plan:
- Reset then normal flow: rst pulse; drive pc 0x100 / instr 0x00500093, then pc 0x104 / instr 0x00108113 → the outputs follow one cycle later with valid_pp=1; before the first edge the outputs are 0 / NOP_INSTR / 0.
- Redirect with default FLUSH_CYCLES=2: pulse Jalr for 1 cycle → exactly 3 consecutive bubble cycles (pc 0, instr 0, valid 0; flushing high for the 2 cycles after the redirect edge), then normal capture resumes; bubble_count = 3.
- Re-trigger: branch_result at edge N, next_select at edge N+1 → bubbles on N through N+3 (4 total); bubble_count = 4.
- Load stall: capture pc 0x200, then hold load high for 3 cycles while the inputs change → the outputs stay at 0x200 / original instr / valid 1; on release, the next input is captured.
- Simultaneous events: load and next_select high together → bubble inserted, not a hold; load held through the countdown → still 3 bubbles; async rst asserted mid-countdown → the outputs go to reset values immediately, and flushing = 0 after release.
- Counter: CNT_WIDTH=2, 5 redirects → bubble_count saturates at 3; count_clear in a bubble cycle → 1.
